// File: rtl/device_mailbox_pkg.sv
// Shared constants and types for the cluster device-space mailbox block:
// register map, STAT bit positions and the bus request bundle.
package device_mailbox_pkg;

  localparam int CID_W  = 3;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;

  localparam logic [ADDR_W-1:0] DEV_ID             = 10'h000;
  localparam logic [ADDR_W-1:0] DEV_CYCLE_LO       = 10'h001;
  localparam logic [ADDR_W-1:0] DEV_CYCLE_HI       = 10'h002;
  localparam logic [ADDR_W-1:0] DEV_MBOX_SEND_BASE = 10'h010;
  localparam logic [ADDR_W-1:0] DEV_MBOX_RECV      = 10'h018;
  localparam logic [ADDR_W-1:0] DEV_MBOX_STAT      = 10'h019;
  localparam logic [ADDR_W-1:0] DEV_LOCK_BASE      = 10'h020;

  localparam int STAT_EMPTY_BIT = 15;
  localparam int STAT_OVF_BIT   = 14;

  typedef struct packed {
    logic [CID_W-1:0]  cid;
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dev_req_t;

  // True when a falls in [base, base+n).
  function automatic logic in_window(logic [ADDR_W-1:0] a, logic [ADDR_W-1:0] base, int n);
    return (int'(a) >= int'(base)) && (int'(a) < int'(base) + n);
  endfunction

endpackage

// File: rtl/mailbox_fifo.sv
// Single inter-core mailbox: circular FIFO with a combinational head and a
// sticky overflow flag set when a push arrives while full.
module mailbox_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  input  logic             clr_overflow
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A dropped push wins over a same-cycle clear so the loss is never hidden.
      if (push && full)      overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/device_mailbox.sv
// Cluster device-space peripheral: core id, cycle counter with coherent HI
// snapshot, per-core mailbox FIFOs and test-and-set spinlocks.
module device_mailbox
  import device_mailbox_pkg::*;
#(
  parameter int NUM_CORES     = 8,
  parameter int MAILBOX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CID_W-1:0]  core_id,
  input  logic              write_en,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data
);

  localparam int CW = $clog2(MAILBOX_DEPTH) + 1;

  dev_req_t req;
  // A simultaneous write suppresses the read entirely, including side effects.
  assign req = '{cid: core_id, wr: write_en, rd: read_en & ~write_en,
                 addr: addr, wdata: write_data};

  logic [31:0]                       cycle_cnt;
  logic [15:0]                       hi_snap;
  logic [NUM_CORES-1:0]              lock_held;
  logic [NUM_CORES-1:0][CID_W-1:0]   lock_owner;

  logic [NUM_CORES-1:0]              push, pop, clr_ovf, f_full, f_empty, f_ovf;
  logic [NUM_CORES-1:0][DATA_W-1:0]  f_dout;
  logic [NUM_CORES-1:0][CW-1:0]      f_count;

  logic                              send_hit, lock_hit;
  logic [CID_W-1:0]                  send_idx, lock_idx;
  logic [DATA_W-1:0]                 rdata_nxt;

  assign send_hit = req.wr && in_window(req.addr, DEV_MBOX_SEND_BASE, NUM_CORES);
  assign send_idx = CID_W'(req.addr - DEV_MBOX_SEND_BASE);
  assign lock_hit = in_window(req.addr, DEV_LOCK_BASE, NUM_CORES);
  assign lock_idx = CID_W'(req.addr - DEV_LOCK_BASE);

  genvar n;
  generate
    for (n = 0; n < NUM_CORES; n++) begin : g_mbox
      assign push[n]    = send_hit && (send_idx == CID_W'(n));
      assign pop[n]     = req.rd && (req.addr == DEV_MBOX_RECV) && (req.cid == CID_W'(n));
      assign clr_ovf[n] = req.rd && (req.addr == DEV_MBOX_STAT) && (req.cid == CID_W'(n));

      mailbox_fifo #(.WIDTH(DATA_W), .DEPTH(MAILBOX_DEPTH)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (push[n]),
        .pop          (pop[n]),
        .din          (req.wdata),
        .dout         (f_dout[n]),
        .count        (f_count[n]),
        .full         (f_full[n]),
        .empty        (f_empty[n]),
        .overflow     (f_ovf[n]),
        .clr_overflow (clr_ovf[n])
      );
    end
  endgenerate

  always_comb begin
    rdata_nxt = '0;
    if (req.rd) begin
      if (req.addr == DEV_ID)
        rdata_nxt = DATA_W'(req.cid);
      else if (req.addr == DEV_CYCLE_LO)
        rdata_nxt = cycle_cnt[15:0];
      else if (req.addr == DEV_CYCLE_HI)
        rdata_nxt = hi_snap;
      else if (req.addr == DEV_MBOX_RECV)
        rdata_nxt = f_empty[req.cid] ? '0 : f_dout[req.cid];
      else if (req.addr == DEV_MBOX_STAT) begin
        rdata_nxt[STAT_EMPTY_BIT] = f_empty[req.cid];
        rdata_nxt[STAT_OVF_BIT]   = f_ovf[req.cid];
        rdata_nxt[2:0] = f_full[req.cid] ? 3'(MAILBOX_DEPTH) : 3'(f_count[req.cid]);
      end else if (lock_hit)
        rdata_nxt = DATA_W'(!lock_held[lock_idx]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data  <= '0;
      cycle_cnt  <= '0;
      hi_snap    <= '0;
      lock_held  <= '0;
      lock_owner <= '0;
    end else begin
      read_data <= rdata_nxt;
      cycle_cnt <= cycle_cnt + 32'd1;
      // Capturing HI with LO keeps the pair coherent across the 16-bit carry.
      if (req.rd && req.addr == DEV_CYCLE_LO) hi_snap <= cycle_cnt[31:16];
      if (lock_hit) begin
        if (req.rd && !lock_held[lock_idx]) begin
          lock_held[lock_idx]  <= 1'b1;
          lock_owner[lock_idx] <= req.cid;
        end else if (req.wr && lock_held[lock_idx] && lock_owner[lock_idx] == req.cid) begin
          lock_held[lock_idx]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_device_mailbox.sv
// Bench for device_mailbox: directed vector table, randomized traffic against
// a queue-based reference model, counter carry/wrap and async reset sequences.
module tb_device_mailbox;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  core_id = '0;
  logic        write_en = 1'b0, read_en = 1'b0;
  logic [9:0]  addr = '0;
  logic [15:0] write_data = '0;
  logic [15:0] read_data;

  device_mailbox #(.NUM_CORES(8), .MAILBOX_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .core_id(core_id), .write_en(write_en),
    .read_en(read_en), .addr(addr), .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0;

  // Reference model: a queue per mailbox, flag/owner arrays, a plain counter.
  logic [15:0] mq[8][$];
  bit          movf[8];
  bit          mheld[8];
  int          mown[8];
  logic [31:0] mcnt;
  logic [15:0] mhi;

  typedef struct {
    logic [2:0]  cid;
    bit          we;
    bit          re;
    logic [9:0]  a;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(int cid, bit we, bit re, int a, int wd, int exp);
    vec_t v;
    v.cid = 3'(cid); v.we = we; v.re = re; v.a = 10'(a); v.wd = 16'(wd); v.exp = 16'(exp);
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: read_data=%h expected %h", name, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      mq[k].delete(); movf[k] = 0; mheld[k] = 0; mown[k] = 0;
    end
    mcnt = '0; mhi = '0;
  endtask

  task automatic model_step(input logic [2:0] cid, input bit we, input bit re,
                            input logic [9:0] a, input logic [15:0] wd,
                            output logic [15:0] e);
    int n;
    e = '0;
    if (we) begin
      if (a >= 10'h010 && a < 10'h018) begin
        n = int'(a) - 16;
        if (mq[n].size() < 4) mq[n].push_back(wd);
        else movf[n] = 1;
      end else if (a >= 10'h020 && a < 10'h028) begin
        n = int'(a) - 32;
        if (mheld[n] && mown[n] == int'(cid)) mheld[n] = 0;
      end
    end else if (re) begin
      if (a == 10'h000) e = 16'(cid);
      else if (a == 10'h001) begin e = mcnt[15:0]; mhi = mcnt[31:16]; end
      else if (a == 10'h002) e = mhi;
      else if (a == 10'h018) begin
        if (mq[cid].size() > 0) e = mq[cid].pop_front();
      end else if (a == 10'h019) begin
        e = 16'(mq[cid].size());
        e[15] = (mq[cid].size() == 0);
        e[14] = movf[cid];
        movf[cid] = 0;
      end else if (a >= 10'h020 && a < 10'h028) begin
        n = int'(a) - 32;
        if (!mheld[n]) begin e = 16'd1; mheld[n] = 1; mown[n] = int'(cid); end
      end
    end
    mcnt = mcnt + 32'd1;
  endtask

  // Called just after a negedge; returns read_data sampled 1 time unit after the next posedge.
  task automatic cycle(input logic [2:0] cid, input bit we, input bit re,
                       input logic [9:0] a, input logic [15:0] wd, output logic [15:0] got);
    core_id = cid; write_en = we; read_en = re; addr = a; write_data = wd;
    @(posedge clk);
    #1 got = read_data;
    @(negedge clk);
    write_en = 1'b0; read_en = 1'b0;
  endtask

  task automatic op(input string name, input int cid, input bit we, input bit re,
                    input int a, input int wd);
    logic [15:0] e, g;
    model_step(3'(cid), we, re, 10'(a), 16'(wd), e);
    cycle(3'(cid), we, re, 10'(a), 16'(wd), g);
    check(name, g, e);
  endtask

  initial begin
    logic [15:0] e, g;
    int cid, k, sel, a;

    tbl.push_back(mk(5, 0, 1, 'h000, 0, 'h0005));
    tbl.push_back(mk(5, 0, 0, 'h000, 0, 'h0000));
    tbl.push_back(mk(2, 1, 0, 'h013, 'h1111, 0));
    tbl.push_back(mk(2, 1, 0, 'h013, 'h2222, 0));
    tbl.push_back(mk(2, 1, 0, 'h013, 'h3333, 0));
    tbl.push_back(mk(2, 1, 0, 'h013, 'h4444, 0));
    tbl.push_back(mk(2, 1, 0, 'h013, 'h5555, 0));
    tbl.push_back(mk(3, 0, 1, 'h019, 0, 'h4004));
    tbl.push_back(mk(3, 0, 1, 'h018, 0, 'h1111));
    tbl.push_back(mk(3, 0, 1, 'h018, 0, 'h2222));
    tbl.push_back(mk(3, 0, 1, 'h018, 0, 'h3333));
    tbl.push_back(mk(3, 0, 1, 'h018, 0, 'h4444));
    tbl.push_back(mk(3, 0, 1, 'h019, 0, 'h8000));
    tbl.push_back(mk(3, 0, 1, 'h018, 0, 'h0000));
    tbl.push_back(mk(1, 0, 1, 'h024, 0, 'h0001));
    tbl.push_back(mk(4, 0, 1, 'h024, 0, 'h0000));
    tbl.push_back(mk(4, 1, 0, 'h024, 'hFFFF, 0));
    tbl.push_back(mk(4, 0, 1, 'h024, 0, 'h0000));
    tbl.push_back(mk(1, 0, 1, 'h024, 0, 'h0000));
    tbl.push_back(mk(1, 1, 0, 'h024, 0, 0));
    tbl.push_back(mk(4, 0, 1, 'h024, 0, 'h0001));
    tbl.push_back(mk(0, 1, 1, 'h010, 'hABCD, 'h0000));
    tbl.push_back(mk(0, 0, 1, 'h019, 0, 'h0001));
    tbl.push_back(mk(0, 0, 1, 'h018, 0, 'hABCD));
    tbl.push_back(mk(2, 1, 0, 'h000, 'h1234, 0));
    tbl.push_back(mk(2, 0, 1, 'h005, 0, 'h0000));
    tbl.push_back(mk(6, 0, 1, 'h019, 0, 'h8000));

    // Reset state, including a read strobe held while in reset.
    repeat (2) @(negedge clk);
    check("reset_rdata", read_data, 16'h0);
    core_id = 3'd5; read_en = 1'b1;
    @(posedge clk);
    #1 check("reset_hold", read_data, 16'h0);
    @(negedge clk);
    read_en = 1'b0;
    reset = 1'b1;
    model_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      model_step(tbl[i].cid, tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].wd, e);
      cycle(tbl[i].cid, tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].wd, g);
      check($sformatf("vec%0d", i), g, tbl[i].exp);
    end

    for (int i = 0; i < 400; i++) begin
      cid = int'($urandom_range(0, 7));
      k   = int'($urandom_range(0, 9));
      sel = int'($urandom_range(0, 8));
      case (sel)
        0: a = 'h000;
        1: a = 'h001;
        2: a = 'h002;
        3, 8: a = 'h010 + int'($urandom_range(0, 7));
        4: a = 'h018;
        5: a = 'h019;
        6: a = 'h020 + int'($urandom_range(0, 7));
        default: a = int'($urandom_range(0, 1023));
      endcase
      op($sformatf("rand%0d", i), cid, (k >= 4 && k <= 8), (k <= 3 || k == 8), a,
         int'($urandom_range(0, 65535)));
    end

    // LO/HI coherence across the 16-bit carry.
    force dut.cycle_cnt = 32'h0000FFFE;
    #1 release dut.cycle_cnt;
    mcnt = 32'h0000FFFE;
    op("cnt_lo_a", 1, 0, 1, 'h001, 0);
    op("cnt_lo_b", 2, 0, 1, 'h001, 0);
    op("cnt_hi_b", 3, 0, 1, 'h002, 0);
    op("cnt_lo_c", 4, 0, 1, 'h001, 0);
    op("cnt_hi_c", 5, 0, 1, 'h002, 0);

    // 32-bit wrap.
    force dut.cycle_cnt = 32'hFFFFFFFE;
    #1 release dut.cycle_cnt;
    mcnt = 32'hFFFFFFFE;
    op("wrap_lo_a", 0, 0, 1, 'h001, 0);
    op("wrap_hi_a", 0, 0, 1, 'h002, 0);
    op("wrap_lo_b", 0, 0, 1, 'h001, 0);
    op("wrap_hi_b", 0, 0, 1, 'h002, 0);

    // Asynchronous reset with mailboxes partly full and a lock held.
    op("pre_push1", 0, 1, 0, 'h011, 'h0A0A);
    op("pre_push5", 0, 1, 0, 'h015, 'h0B0B);
    op("pre_push5b", 0, 1, 0, 'h015, 'h0C0C);
    op("pre_lock7", 2, 0, 1, 'h027, 0);
    core_id = 3'd6; read_en = 1'b1; addr = 10'h000;
    @(posedge clk);
    #1 check("pre_reset_id", read_data, 16'h0006);
    #2 reset = 1'b0;
    #1 check("async_clear", read_data, 16'h0);
    @(posedge clk);
    #1 check("in_reset", read_data, 16'h0);
    @(negedge clk);
    read_en = 1'b0;
    reset = 1'b1;
    model_reset();
    op("post_stat1", 1, 0, 1, 'h019, 0);
    op("post_stat5", 5, 0, 1, 'h019, 0);
    op("post_recv5", 5, 0, 1, 'h018, 0);
    op("post_lock7", 3, 0, 1, 'h027, 0);
    op("post_cnt", 0, 0, 1, 'h001, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/device_mailbox.md
Name: device_mailbox

Overview:
- Device-space peripheral on the cluster's device bus: the window where core address[15:10] == 6'b111111.
- Consumes the shared request already muxed for the granted core (core id, read/write strobes, 10-bit address, write data).
- Returns read data one cycle later, matching the registered device-select read-back path.
- Provides per-core identity, a 32-bit cycle counter, eight inter-core mailbox FIFOs and eight hardware spinlocks.

Parameters:
NUM_CORES, 8, number of cores, mailboxes and lock owners (core id width 3).
MAILBOX_DEPTH, 4, entries per mailbox FIFO (power of two, >= 2).

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset. Cluster's active-high reset is inverted at instantiation.
core_id  input  3  id of the core owning the current bus slot
write_en  input  1  device write strobe
read_en  input  1  device read strobe
addr  input  10  device word address
write_data  input  16  write data
read_data  output  16  read data, valid the cycle after read_en

Behaviour:
- Reset (reset==0, async): read_data=0; cycle counter=0; all FIFOs empty with overflow flags clear; all locks free; hi-snapshot=0.
- One access per cycle. If write_en and read_en are both 1, the write is performed, the read has no side effect, and read_data<=0.
- read_data is registered and loaded on every clk edge:
  - read_en=1: loaded with the decoded value.
  - otherwise: loaded with 0.
  - Latency is exactly 1 cycle.
- Read side effects commit on the same edge that samples read_en.
- Address map (reads of unmapped addresses return 0; writes to unmapped or read-only addresses are ignored):
  - 0x000 ID (R): {13'b0, core_id}.
  - 0x001 CYCLE_LO (R): counter[15:0]. The same edge captures counter[31:16] into the hi-snapshot.
  - 0x002 CYCLE_HI (R): hi-snapshot (last value captured by any core's CYCLE_LO read).
  - 0x010+n, n=0..7, MBOX_SEND (W): push write_data into core n's FIFO.
  - 0x018 MBOX_RECV (R): pop head of FIFO[core_id]. If empty, returns 0 and pointers are unchanged.
  - 0x019 MBOX_STAT (R): {empty, overflow, 11'b0, count[2:0]}, where count is the number of entries (0..MAILBOX_DEPTH). Reading clears overflow for FIFO[core_id] only.
  - 0x020+n LOCK (R): test-and-set.
    - Lock n free: becomes owned by core_id, returns 1.
    - Lock n held, including by the requester: returns 0, no change.
  - 0x020+n LOCK (W): release, only if owner==core_id; a release from a non-owner is ignored. write_data is ignored.
- Cycle counter: +1 every cycle, 32-bit, wraps 0xFFFFFFFF -> 0. The count value at the read edge is returned.
- FIFO push when full: data is dropped, overflow is set (sticky), count stays at MAILBOX_DEPTH.
- Pointers wrap modulo MAILBOX_DEPTH. Ordering is strict FIFO per mailbox.
- A core may send to its own mailbox.
- Reset asserted mid-operation: state clears immediately. A read issued in the cycle reset deasserts behaves normally on the next edge.

Decomposition:
- Shared include device_defines.vh holds:
  - address constants: DEV_ID, DEV_CYCLE_LO, DEV_CYCLE_HI, DEV_MBOX_SEND_BASE, DEV_MBOX_RECV, DEV_MBOX_STAT, DEV_LOCK_BASE;
  - the STAT bit positions (empty=15, overflow=14).
- One sub-module, mailbox_fifo:
  - parameters: WIDTH=16, DEPTH;
  - ports: push, pop, din, dout (head, combinational), count, full, empty, overflow, clr_overflow;
  - instantiated NUM_CORES times via generate.
- Lock state lives in the top module: per lock, a held bit plus a 3-bit owner.

Test Plan:
- Reset, then read 0x000 with core_id=5 -> read_data=0x0005 exactly one cycle after read_en; read_data=0 in the other cycles.
- Core 2 writes 0x1111, 0x2222, 0x3333, 0x4444, 0x5555 to 0x013 -> core 3 reads 0x019 = 0x4004 (full, overflow set); pops return 0x1111..0x4444; the next 0x019 read = 0x8000; a further pop returns 0.
- Core 1 reads 0x024 -> 1. Core 4 reads 0x024 -> 0. Core 4 writes 0x024 -> lock still held. Core 1 writes 0x024 -> free; core 4 reads 0x024 -> 1.
- Preload counter near 0x0000FFFF (force or wait) and read 0x001 then 0x002 -> LO/HI pair is coherent across the 16-bit carry. Separately, after 0xFFFFFFFF the counter reads 0.
- write_en and read_en both asserted on 0x010 with core_id=0 -> FIFO0 gains the entry; read_data=0 next cycle.
- Assert reset mid-sequence with FIFOs partly full and a lock held -> all FIFOs empty, locks free, and read_data=0 immediately, without waiting for a clock edge.
